// File: rtl/arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_DONE
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins outright, and on a tie
// the port that was not granted last wins.
module rr_pick2
  import arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic pick
);

  always_comb begin
    valid = req0 | req1;
    pick  = PORT_CPU;
    if (req0 && req1) begin
      pick = ~last_grant;
    end else if (req1) begin
      pick = PORT_AUX;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported Memoria between the CPU and an auxiliary master,
// holding the granted request on the memory bus for MEM_LAT cycles.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              grant,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int               CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              grant_q, grant_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic pick_valid;
  logic pick_port;

  rr_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (grant_q),
    .valid      (pick_valid),
    .pick       (pick_port)
  );

  // NOTE: every _d takes its current value first, so no path through this block infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_port;
          addr_d  = (pick_port == PORT_AUX) ? addr1  : addr0;
          wr_d    = (pick_port == PORT_AUX) ? wr1    : wr0;
          wdata_d = (pick_port == PORT_AUX) ? wdata1 : wdata0;
          cnt_d   = CNT_LOAD;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        // Memoria's data is valid on the last latency cycle; writes leave rdata alone.
        if (cnt_q == CNT_ONE) begin
          if (!wr_q) begin
            rdata_d = mem_rdata;
          end
          state_d = ARB_DONE;
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register updates from the same pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      grant_q <= PORT_AUX;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // mem_wr is decoded from state so an asynchronous reset drops it immediately.
  assign mem_wr    = (state_q == ARB_BUSY) && wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != ARB_IDLE);
  assign ack0      = (state_q == ARB_DONE) && (grant_q == PORT_CPU);
  assign ack1      = (state_q == ARB_DONE) && (grant_q == PORT_AUX);
  assign grant     = grant_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int LAT = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0, req1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, grant, busy, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, rdata;

  // Bench-side Memoria: combinational read, write applied once per cycle.
  logic [DW-1:0] mem_arr [256];
  assign mem_rdata = mem_arr[mem_addr[7:0]];

  always #5 clock = ~clock;

  mem_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .MEM_LAT (LAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wr0       (wr0),
    .wr1       (wr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata     (rdata),
    .grant     (grant),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_raise0 = 0;
  int t_raise1 = 0;

  // Reference model: one access spans cycles 1..LAT (memory busy) and LAT+1 (ack).
  int            m_phase;
  logic          m_port, m_last, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [DW-1:0] ref_mem [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_port  = 1'b0;
    m_last  = 1'b1;
    m_wr    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_rdata = '0;
  endtask

  task automatic model_step();
    if (m_phase == 0) begin
      if (req0 || req1) begin
        m_port  = (req0 && req1) ? ~m_last : req1;
        m_last  = m_port;
        m_addr  = m_port ? addr1  : addr0;
        m_wr    = m_port ? wr1    : wr0;
        m_wdata = m_port ? wdata1 : wdata0;
        m_phase = 1;
      end
    end else if (m_phase <= LAT) begin
      if (m_phase == 1 && m_wr) ref_mem[m_addr[7:0]] = m_wdata;
      if (m_phase == LAT && !m_wr) m_rdata = ref_mem[m_addr[7:0]];
      m_phase++;
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic check_outputs();
    check("busy",      32'(busy),   32'(m_phase != 0));
    check("mem_wr",    32'(mem_wr), 32'((m_phase >= 1) && (m_phase <= LAT) && m_wr));
    check("ack0",      32'(ack0),   32'((m_phase == LAT + 1) && !m_port));
    check("ack1",      32'(ack1),   32'((m_phase == LAT + 1) && m_port));
    check("grant",     32'(grant),  32'(m_last));
    check("mem_addr",  mem_addr,    m_addr);
    check("mem_wdata", mem_wdata,   m_wdata);
    check("rdata",     rdata,       m_rdata);
  endtask

  // Inputs set before tick() are sampled at the coming rising edge.
  task automatic tick();
    model_step();
    @(negedge clock);
    cyc++;
    if (mem_wr) mem_arr[mem_addr[7:0]] = mem_wdata;
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clock);
    cyc++;
    check_outputs();
    reset = 1'b0;
  endtask

  task automatic raise(input int p);
    if (p == 0) begin
      req0     = 1'b1;
      addr0    = $urandom_range(0, 255);
      wr0      = 1'($urandom_range(0, 1));
      wdata0   = $urandom;
      t_raise0 = cyc;
    end else begin
      req1     = 1'b1;
      addr1    = $urandom_range(0, 255);
      wr1      = 1'($urandom_range(0, 1));
      wdata1   = $urandom;
      t_raise1 = cyc;
    end
  endtask

  initial begin
    int n_ack0;
    int n_ack1;
    int total;
    int seq [8];

    reset  = 1'b1;
    req0   = 1'b0;
    req1   = 1'b0;
    wr0    = 1'b0;
    wr1    = 1'b0;
    addr0  = '0;
    addr1  = '0;
    wdata0 = '0;
    wdata1 = '0;
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[8'h40] = 32'hDEADBEEF;
    ref_mem[8'h40] = 32'hDEADBEEF;
    model_reset();

    // Reset values
    @(negedge clock);
    check("rst_ack0",      32'(ack0),   32'd0);
    check("rst_ack1",      32'(ack1),   32'd0);
    check("rst_busy",      32'(busy),   32'd0);
    check("rst_mem_wr",    32'(mem_wr), 32'd0);
    check("rst_mem_addr",  mem_addr,    32'd0);
    check("rst_mem_wdata", mem_wdata,   32'd0);
    check("rst_rdata",     rdata,       32'd0);
    check("rst_grant",     32'(grant),  32'd1);
    reset = 1'b0;

    // Single read by port 0
    req0 = 1'b1; addr0 = 32'h40; wr0 = 1'b0; wdata0 = '0;
    tick(); check("rd_wr_c1", 32'(mem_wr), 32'd0); check("rd_addr_c1", mem_addr, 32'h40);
    tick(); check("rd_wr_c2", 32'(mem_wr), 32'd0);
    tick();
    check("rd_ack0",  32'(ack0),  32'd1);
    check("rd_rdata", rdata,      32'hDEADBEEF);
    check("rd_grant", 32'(grant), 32'd0);
    req0 = 1'b0;
    tick(); check("rd_idle", 32'(busy), 32'd0);

    // Write by port 1
    req1 = 1'b1; addr1 = 32'h80; wr1 = 1'b1; wdata1 = 32'h1234;
    for (int c = 1; c <= 2; c++) begin
      tick();
      check("wr_mem_wr", 32'(mem_wr), 32'd1);
      check("wr_addr",   mem_addr,    32'h80);
      check("wr_wdata",  mem_wdata,   32'h1234);
    end
    tick();
    check("wr_ack1",       32'(ack1),   32'd1);
    check("wr_mem_wr_end", 32'(mem_wr), 32'd0);
    check("wr_rdata_kept", rdata,       32'hDEADBEEF);
    req1 = 1'b0;
    tick();
    check("wr_mem_content", mem_arr[8'h80], 32'h1234);

    // Tie after reset: port 0 first, then port 1
    do_reset();
    req0 = 1'b1; addr0 = 32'h10; wr0 = 1'b1; wdata0 = 32'hAAAA0000;
    req1 = 1'b1; addr1 = 32'h20; wr1 = 1'b1; wdata1 = 32'hBBBB1111;
    for (int c = 1; c <= 2; c++) begin
      tick();
      check("tie_p0_addr",  mem_addr,  32'h10);
      check("tie_p0_wdata", mem_wdata, 32'hAAAA0000);
    end
    tick();
    check("tie_ack0",    32'(ack0), 32'd1);
    check("tie_no_ack1", 32'(ack1), 32'd0);
    req0 = 1'b0;
    tick(); check("tie_idle_c4", 32'(busy), 32'd0);
    for (int c = 5; c <= 6; c++) begin
      tick();
      check("tie_p1_grant", 32'(grant), 32'd1);
      check("tie_p1_addr",  mem_addr,   32'h20);
      check("tie_p1_wdata", mem_wdata,  32'hBBBB1111);
    end
    tick(); check("tie_ack1_c7", 32'(ack1), 32'd1);
    req1 = 1'b0;
    tick();

    // Fairness: both ports keep requesting
    do_reset();
    raise(0);
    raise(1);
    n_ack0 = 0;
    n_ack1 = 0;
    total  = 0;
    for (int c = 0; c < 100 && total < 8; c++) begin
      tick();
      if (!req0) raise(0);
      if (!req1) raise(1);
      if (ack0 || ack1) begin
        seq[total] = ack1 ? 1 : 0;
        total++;
        if (ack0) begin n_ack0++; req0 = 1'b0; end
        if (ack1) begin n_ack1++; req1 = 1'b0; end
      end
    end
    check("fair_total", 32'(total), 32'd8);
    for (int i = 0; i < 8; i++) check("fair_seq", 32'(seq[i]), 32'(i % 2));
    check("fair_acks0", 32'(n_ack0), 32'd4);
    check("fair_acks1", 32'(n_ack1), 32'd4);

    // Reset during the second busy cycle of a write
    do_reset();
    req1 = 1'b1; addr1 = 32'h90; wr1 = 1'b1; wdata1 = 32'hC0FFEE00;
    tick(); check("rmid_wr_c1", 32'(mem_wr), 32'd1);
    tick(); check("rmid_wr_c2", 32'(mem_wr), 32'd1);
    reset = 1'b1;
    model_reset();
    #1;
    check("rmid_wr_drop", 32'(mem_wr), 32'd0);
    check("rmid_busy",    32'(busy),   32'd0);
    check("rmid_ack1",    32'(ack1),   32'd0);
    check("rmid_grant",   32'(grant),  32'd1);
    @(negedge clock);
    cyc++;
    check_outputs();
    check("rmid_no_ack", 32'(ack1), 32'd0);
    reset = 1'b0;
    tick(); check("rmid_retry_wr", 32'(mem_wr), 32'd1); check("rmid_retry_addr", mem_addr, 32'h90);
    tick();
    tick(); check("rmid_retry_ack1", 32'(ack1), 32'd1);
    req1 = 1'b0;
    tick();

    // req0 held one cycle past its ack starts a second access
    req0 = 1'b1; addr0 = 32'h40; wr0 = 1'b0;
    tick();
    tick();
    tick(); check("hold_ack_c3", 32'(ack0), 32'd1);
    tick(); check("hold_idle_c4", 32'(busy), 32'd0);
    tick(); check("hold_busy_c5", 32'(busy), 32'd1);
    req0 = 1'b0;
    tick();
    tick(); check("hold_ack_c7", 32'(ack0), 32'd1);
    tick();

    // Random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      if (ack0) begin
        check("lat_bound0", 32'((cyc - t_raise0) <= 2 * LAT + 3), 32'd1);
        req0 = 1'b0;
      end else if (!req0 && $urandom_range(0, 2) == 0) begin
        raise(0);
      end
      if (ack1) begin
        check("lat_bound1", 32'((cyc - t_raise1) <= 2 * LAT + 3), 32'd1);
        req1 = 1'b0;
      end else if (!req1 && $urandom_range(0, 2) == 0) begin
        raise(1);
      end
      tick();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    for (int i = 0; i < LAT + 3; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
